// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared type definitions for the pipeline's memory-side blocks.
//   arbStateT : sequencing states of the memory port arbiter
//   ownerT    : which pipeline port owns the access currently in flight
// ---------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arbStateT;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } ownerT;

endpackage

// File: rtl/starve_counter.sv
// ---------------------------------------------------------------------------
// starve_counter
// Saturating counter of data-port grants made while the fetch port waits.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset (count -> 0)
//   inc          in   count one more grant (ignored once saturated)
//   clr          in   clear to zero (has priority over inc)
//   limitReached out  count has reached STARVE_LIMIT
// ---------------------------------------------------------------------------
module starve_counter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limitReached
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !limitReached) begin
            count <= count + CNT_W'(1);
        end
    end

    assign limitReached = (count == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between the fetch stage (I-port)
// and the memory stage (D-port). Each access is sequenced IDLE -> BUSY ->
// RESP; BUSY lasts until mem_ready. The data port wins by default, but after
// STARVE_LIMIT consecutive data grants while a fetch waits, the fetch wins.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_req/i_addr                  fetch request, held until i_done
//   i_rdata/i_done                fetched word (registered) + 1-cycle pulse
//   d_req/d_we/d_addr/d_wdata     load/store request, held until d_done
//   d_rdata/d_done                load data (registered) + 1-cycle pulse
//   mem_req/mem_we/mem_addr/mem_wdata  memory command, valid in BUSY only
//   mem_rdata/mem_ready           memory response, sampled in BUSY only
//   stall_i/stall_d               request pending and not completing now
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_i,
    output logic          stall_d
);

    arbStateT      state;
    arbStateT      nextState;
    ownerT         ownerQ;
    logic [AW-1:0] addrQ;
    logic          weQ;
    logic [DW-1:0] wdataQ;
    logic          grantD;
    logic          grantI;
    logic          starveLimit;

    // Grants are only made from IDLE. A saturated starvation count hands the
    // slot to a waiting fetch even when the data port is also requesting.
    assign grantD = (state == IDLE) && d_req && !(i_req && starveLimit);
    assign grantI = (state == IDLE) && i_req && !grantD;

    starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) uStarveCounter (
        .clk          (clk),
        .rst          (rst),
        .inc          (grantD && i_req),
        .clr          (grantI),
        .limitReached (starveLimit)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (grantD || grantI) nextState = BUSY;
            BUSY:    if (mem_ready)        nextState = RESP;
            RESP:                          nextState = IDLE;
            default:                       nextState = IDLE;
        endcase
    end

    // Output logic: the memory command is only driven while BUSY, and the
    // owner's done pulse is exactly the single RESP cycle.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        case (state)
            BUSY: begin
                mem_req   = 1'b1;
                mem_we    = weQ;
                mem_addr  = addrQ;
                mem_wdata = wdataQ;
            end
            RESP: begin
                i_done = (ownerQ == OWN_I);
                d_done = (ownerQ == OWN_D);
            end
            default: ;
        endcase
    end

    // Access latch and response capture. The requester may drop its request
    // during BUSY; the latched command keeps the access going to completion.
    // NOTE: every register here is reset, including the rdata holding
    // registers, because their values are directly visible on the ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ownerQ  <= OWN_I;
            addrQ   <= '0;
            weQ     <= 1'b0;
            wdataQ  <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (grantD) begin
                ownerQ <= OWN_D;
                addrQ  <= d_addr;
                weQ    <= d_we;
                wdataQ <= d_wdata;
            end else if (grantI) begin
                ownerQ <= OWN_I;
                addrQ  <= i_addr;
                weQ    <= 1'b0;
                wdataQ <= '0;
            end

            if (state == BUSY && mem_ready) begin
                if (ownerQ == OWN_I) begin
                    i_rdata <= mem_rdata;
                end else if (!weQ) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

    assign stall_i = i_req & ~i_done;
    assign stall_d = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          stall_i;
    logic          stall_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_i   (stall_i),
        .stall_d   (stall_d)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One outstanding access at most: "accessOpen" while the memory is being
    // driven, "answerDue" for the cycle the requester is told it finished.
    bit          accessOpen;
    bit          answerDue;
    bit          forD;
    bit          isStore;
    logic [31:0] accAddr;
    logic [31:0] accData;
    logic [31:0] fetchWord;
    logic [31:0] loadWord;
    int          dWinsWhileIWaits;
    bit          grantLog[$];

    bit lastIDone, lastDDone, lastMemReq;

    task automatic modelReset();
        accessOpen       = 0;
        answerDue        = 0;
        forD             = 0;
        isStore          = 0;
        accAddr          = '0;
        accData          = '0;
        fetchWord        = '0;
        loadWord         = '0;
        dWinsWhileIWaits = 0;
    endtask

    task automatic modelCompare();
        bit expIDone;
        bit expDDone;
        expIDone = answerDue && !forD;
        expDDone = answerDue && forD;
        check("mem_req", mem_req, accessOpen);
        check("mem_we", mem_we, accessOpen && isStore);
        if (accessOpen || rst) check("mem_addr", mem_addr, accessOpen ? accAddr : 32'h0);
        if ((accessOpen && isStore) || rst)
            check("mem_wdata", mem_wdata, (accessOpen && isStore) ? accData : 32'h0);
        check("i_done", i_done, expIDone);
        check("d_done", d_done, expDDone);
        check("i_rdata", i_rdata, fetchWord);
        check("d_rdata", d_rdata, loadWord);
        check("stall_i", stall_i, i_req && !expIDone);
        check("stall_d", stall_d, d_req && !expDDone);
    endtask

    task automatic modelAdvance();
        bit fetchForced;
        fetchForced = i_req && (dWinsWhileIWaits == LIM);
        if (answerDue) begin
            answerDue = 0;
        end else if (accessOpen) begin
            if (mem_ready) begin
                if (!forD)          fetchWord = mem_rdata;
                else if (!isStore)  loadWord  = mem_rdata;
                accessOpen = 0;
                answerDue  = 1;
            end
        end else if (d_req && !fetchForced) begin
            forD = 1; isStore = d_we; accAddr = d_addr; accData = d_wdata;
            accessOpen = 1;
            if (i_req && dWinsWhileIWaits < LIM) dWinsWhileIWaits++;
            grantLog.push_back(1'b1);
        end else if (i_req) begin
            forD = 0; isStore = 0; accAddr = i_addr; accData = '0;
            accessOpen = 1;
            dWinsWhileIWaits = 0;
            grantLog.push_back(1'b0);
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model, then
    // return 1 time unit after the next rising edge for the caller to drive.
    task automatic tick();
        @(negedge clk);
        if (rst) modelReset();
        modelCompare();
        lastIDone  = i_done;
        lastDDone  = d_done;
        lastMemReq = mem_req;
        if (!rst) modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        tick();
        tick();
        grantLog.delete();
        rst = 1'b0;
    endtask

    bit expSeq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        int dDones, iDones, memReqs, maxIWait, iWait;
        bit doneSeq[$];
        int doneCycles[$];
        bit iActive, dActive;

        modelReset();
        doReset();
        check("reset_mem_req", mem_req, 0);
        check("reset_i_rdata", i_rdata, 0);
        check("reset_d_rdata", d_rdata, 0);
        check("reset_dones", {i_done, d_done}, 0);

        // Lone fetch
        i_req = 1; i_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h0050_0093;
        check("fetch_c0_mem_req", mem_req, 0);
        tick();
        check("fetch_c1_mem_req", mem_req, 1);
        check("fetch_c1_mem_addr", mem_addr, 32'h40);
        check("fetch_c1_mem_we", mem_we, 0);
        tick();
        check("fetch_c2_i_done", i_done, 1);
        check("fetch_c2_i_rdata", i_rdata, 32'h0050_0093);
        check("fetch_c2_stall_i", stall_i, 0);
        tick();
        i_req = 0;
        tick();

        // Store with three wait states
        doReset();
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        mem_ready = 0; mem_rdata = 32'h1234_5678;
        dDones = 0;
        tick();
        dDones += int'(lastDDone);
        for (int k = 1; k <= 4; k++) begin
            mem_ready = (k == 4);
            check("store_busy_we", mem_we, 1);
            check("store_busy_addr", mem_addr, 32'h100);
            check("store_busy_wdata", mem_wdata, 32'hDEAD_BEEF);
            tick();
            dDones += int'(lastDDone);
        end
        check("store_resp_d_done", d_done, 1);
        check("store_resp_mem_req", mem_req, 0);
        check("store_d_rdata_kept", d_rdata, 0);
        tick();
        dDones += int'(lastDDone);
        d_req = 0; d_we = 0; mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            dDones += int'(lastDDone);
        end
        check("store_d_done_count", dDones, 1);

        // Simultaneous requests: D,D,D,D,I repeating
        doReset();
        i_req = 1; i_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h300; mem_ready = 1;
        for (int c = 0; c < 30; c++) begin
            mem_rdata = $urandom();
            tick();
            if (lastIDone) doneSeq.push_back(1'b0);
            if (lastDDone) doneSeq.push_back(1'b1);
        end
        check("simul_done_count", doneSeq.size(), 10);
        check("simul_model_grants", grantLog.size() >= 10, 1);
        for (int k = 0; k < 10; k++) begin
            if (k < doneSeq.size()) check($sformatf("simul_done_owner_%0d", k), doneSeq[k], expSeq[k]);
            if (k < grantLog.size()) check($sformatf("model_grant_owner_%0d", k), grantLog[k], expSeq[k]);
        end
        i_req = 0; d_req = 0;
        tick(); tick(); tick();

        // Back-to-back loads, then reset in the middle of a third one
        doReset();
        d_req = 1; d_we = 0; d_addr = 32'h200; mem_ready = 1; mem_rdata = 32'h11;
        for (int c = 0; c < 9; c++) begin
            if (c == 2) check("b2b_first_rdata", d_rdata, 32'h11);
            if (c == 3) begin d_addr = 32'h204; mem_rdata = 32'h22; end
            if (c == 5) check("b2b_second_rdata", d_rdata, 32'h22);
            if (c == 6) d_req = 0;
            tick();
            if (lastDDone) doneCycles.push_back(c);
        end
        check("b2b_done_count", doneCycles.size(), 2);
        if (doneCycles.size() == 2) begin
            check("b2b_first_done_cycle", doneCycles[0], 2);
            check("b2b_done_spacing", doneCycles[1] - doneCycles[0], 3);
        end

        d_req = 1; d_addr = 32'h208; mem_ready = 0;
        tick();
        check("rst_busy_mem_req_before", mem_req, 1);
        #2 rst = 1;
        #1;
        check("rst_busy_mem_req", mem_req, 0);
        check("rst_busy_mem_addr", mem_addr, 0);
        check("rst_busy_d_rdata", d_rdata, 0);
        check("rst_busy_dones", {i_done, d_done, mem_we}, 0);
        tick();
        rst = 0; d_req = 0;
        dDones = 0; memReqs = 0;
        for (int k = 0; k < 5; k++) begin
            mem_ready = 1;
            tick();
            dDones  += int'(lastDDone);
            memReqs += int'(lastMemReq);
        end
        check("rst_busy_no_done", dDones, 0);
        check("rst_busy_no_mem_req", memReqs, 0);

        // Requester drops during BUSY
        doReset();
        i_req = 1; i_addr = 32'h44; mem_ready = 0; mem_rdata = 32'hCAFE_0001;
        iDones = 0; memReqs = 0;
        for (int c = 0; c < 9; c++) begin
            if (c == 1) i_req = 0;
            mem_ready = (c == 3);
            if (c == 4) check("drop_i_done", i_done, 1);
            tick();
            iDones  += int'(lastIDone);
            memReqs += int'(lastMemReq);
        end
        check("drop_i_done_count", iDones, 1);
        check("drop_mem_req_cycles", memReqs, 3);
        check("drop_i_rdata", i_rdata, 32'hCAFE_0001);

        // Randomized traffic against the model
        doReset();
        iActive = 0; dActive = 0; iWait = 0; maxIWait = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (iActive && lastIDone) iActive = 0;
            if (dActive && lastDDone) dActive = 0;
            if (!iActive && $urandom_range(0, 2) == 0) begin
                iActive = 1;
                i_addr  = $urandom() & 32'hFFFF_FFFC;
            end
            if (!dActive && $urandom_range(0, 1) == 0) begin
                dActive = 1;
                d_we    = $urandom_range(0, 1);
                d_addr  = $urandom() & 32'hFFFF_FFFC;
                d_wdata = $urandom();
            end
            i_req     = iActive;
            d_req     = dActive;
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom();
            tick();
            iWait = (iActive && !lastIDone) ? iWait + 1 : 0;
            if (iWait > maxIWait) maxIWait = iWait;
        end
        rst = 0;
        check("random_fetch_wait_bound", maxIWait <= 150, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
